draw_particle: RTL and testbench

- Overlay stage between the VGA timing/background chain and the next draw stage.
- Animates one 64x64 particle sprite: launched on request, moved once per frame, retired when off-screen or expired.
- Drives the address of the 64x64 particle ROM, which has 1-cycle registered read latency.
- Merges the returned ROM pixel over the incoming background, with one colour treated as transparent.

---
 rtl/draw_particle.sv | 189 ++++++++++++++++++
 tb/tb_draw_particle.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_particle.sv
// draw_particle: overlay stage that animates a single 64x64 particle sprite over the
// incoming VGA stream.
//
// The particle is launched on request, moved once per frame (on the rising edge of
// vblnk_in) and retired when it leaves the screen or reaches its lifetime. The stage
// drives the address of an external 64x64 particle ROM with 1-cycle read latency and
// composites the returned pixel over the background. One ROM colour is transparent.
//
// Ports:
//   clk60MHz, rst_n             pixel clock, asynchronous active-low reset
//   vcount_in .. rgb_in         incoming timing and background pixel
//   launch, launch_x/y, vel_x   launch request, start corner, signed x velocity
//   rom_rgb / rom_address       particle ROM data in / {row[5:0], col[5:0]} out
//   vcount_out .. hblnk_out     timing delayed by exactly 3 cycles
//   rgb_out                     composited pixel (3-cycle latency)
//   busy                        high while the particle is in flight
//
// Build option: define PARTICLE_GRAVITY_EN to add +1 px/frame vertical acceleration
// saturating at VY_MAX (parabolic arc). Without it vy stays VY_INIT.
module draw_particle #(
  parameter int          SCREEN_W    = 800,
  parameter int          SCREEN_H    = 600,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter int          VY_INIT     = -8,
  parameter int          VY_MAX      = 12,
  parameter int          LIFETIME    = 180
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        launch,
  input  logic [10:0] launch_x,
  input  logic [10:0] launch_y,
  input  logic [3:0]  vel_x,
  input  logic [11:0] rom_rgb,
  output logic [11:0] rom_address,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy
);

  typedef enum logic {StIdle, StFly} state_e;

  localparam logic signed [7:0] VyInitS = VY_INIT[7:0];
`ifdef PARTICLE_GRAVITY_EN
  localparam logic signed [7:0] VyMaxS  = VY_MAX[7:0];
`endif

  // Timing bundle: {vcount, vsync, vblnk, hcount, hsync, hblnk}
  localparam int unsigned TimW = 26;

  state_e             state_q, state_d;
  logic        [10:0] pos_x_q, pos_x_d;
  logic        [10:0] pos_y_q, pos_y_d;
  logic        [3:0]  vx_q, vx_d;
  logic signed [7:0]  vy_q, vy_d;
  logic        [15:0] life_q, life_d;
  logic               vblnk_prev_q;

  logic        [TimW-1:0] tim_in, tim_s1_q, tim_s2_q, tim_s3_q;
  logic        [11:0]     rgb_s1_q, rgb_s2_q, rgb_out_q, rgb_out_d;
  logic                   in_box_d, in_box_s1_q, in_box_s2_q;
  logic        [11:0]     rom_address_q, rom_address_d;

  logic               frame_tick;
  logic signed [12:0] nx, ny;
  logic        [5:0]  col_off, row_off;

  assign tim_in = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in};
  assign {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out} = tim_s3_q;
  assign rgb_out     = rgb_out_q;
  assign rom_address = rom_address_q;
  assign busy        = (state_q == StFly);

  assign frame_tick = vblnk_in & ~vblnk_prev_q;

  // Sprite hit test and ROM address for the incoming pixel (stage 1 inputs).
  // Only the low 6 bits of the offsets are needed, so subtract on 6 bits.
  always_comb begin
    col_off  = hcount_in[5:0] - pos_x_q[5:0];
    row_off  = vcount_in[5:0] - pos_y_q[5:0];
    in_box_d = (state_q == StFly) && !hblnk_in && !vblnk_in &&
               ({1'b0, hcount_in} >= {1'b0, pos_x_q}) &&
               ({1'b0, hcount_in} <= ({1'b0, pos_x_q} + 12'd63)) &&
               ({1'b0, vcount_in} >= {1'b0, pos_y_q}) &&
               ({1'b0, vcount_in} <= ({1'b0, pos_y_q} + 12'd63));
    rom_address_d = in_box_d ? {row_off, col_off} : 12'h000;
  end

  // Stage 3 compositing: ROM data is valid while the hit flag sits in stage 2.
  always_comb begin
    rgb_out_d = rgb_s2_q;
    if (in_box_s2_q && (rom_rgb != TRANSPARENT)) begin
      rgb_out_d = rom_rgb;
    end
  end

  // Motion FSM.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    life_d  = life_q;
    nx      = $signed({2'b00, pos_x_q}) + $signed({{9{vx_q[3]}}, vx_q});
    ny      = $signed({2'b00, pos_y_q}) + $signed({{5{vy_q[7]}}, vy_q});
    unique case (state_q)
      StIdle: begin
        // A launch coinciding with frame_tick is accepted without moving.
        if (launch) begin
          state_d = StFly;
          pos_x_d = launch_x;
          pos_y_d = launch_y;
          vx_d    = vel_x;
          vy_d    = VyInitS;
          life_d  = 16'd0;
        end
      end
      StFly: begin
        if (frame_tick) begin
          life_d = life_q + 16'd1;
          if (nx[12] || (nx >= SCREEN_W) || (ny >= SCREEN_H) ||
              ((life_q + 16'd1) == LIFETIME[15:0])) begin
            state_d = StIdle;
          end else begin
            pos_x_d = nx[10:0];
            // Above the top edge the sprite is pinned to row 0 rather than retired.
            pos_y_d = ny[12] ? 11'd0 : ny[10:0];
`ifdef PARTICLE_GRAVITY_EN
            vy_d = (vy_q >= VyMaxS) ? VyMaxS : (vy_q + 8'sd1);
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      vx_q          <= '0;
      vy_q          <= '0;
      life_q        <= '0;
      vblnk_prev_q  <= 1'b0;
      tim_s1_q      <= '0;
      tim_s2_q      <= '0;
      tim_s3_q      <= '0;
      rgb_s1_q      <= '0;
      rgb_s2_q      <= '0;
      rgb_out_q     <= '0;
      in_box_s1_q   <= 1'b0;
      in_box_s2_q   <= 1'b0;
      rom_address_q <= '0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      life_q        <= life_d;
      vblnk_prev_q  <= vblnk_in;
      tim_s1_q      <= tim_in;
      tim_s2_q      <= tim_s1_q;
      tim_s3_q      <= tim_s2_q;
      rgb_s1_q      <= rgb_in;
      rgb_s2_q      <= rgb_s1_q;
      rgb_out_q     <= rgb_out_d;
      in_box_s1_q   <= in_box_d;
      in_box_s2_q   <= in_box_s1_q;
      rom_address_q <= rom_address_d;
    end
  end

endmodule

// File: tb/tb_draw_particle.sv
// Directed bench for draw_particle. Timing inputs are driven pixel by pixel rather
// than as full frames; frames are advanced by pulsing vblnk_in. LIFETIME is set to 4.
module tb_draw_particle;

  logic        clk60MHz = 1'b0;
  logic        rst_n;
  logic [10:0] vcount_in, hcount_in, launch_x, launch_y;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in, launch;
  logic [11:0] rgb_in, rom_rgb, rom_address, rgb_out;
  logic [3:0]  vel_x;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out, busy;

  logic [11:0] rom_fill;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [11:0] Bg = 12'h5A5;

  draw_particle #(.LIFETIME(4)) dut (
    .clk60MHz   (clk60MHz),
    .rst_n      (rst_n),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .launch     (launch),
    .launch_x   (launch_x),
    .launch_y   (launch_y),
    .vel_x      (vel_x),
    .rom_rgb    (rom_rgb),
    .rom_address(rom_address),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out),
    .busy       (busy)
  );

  always #5 clk60MHz = ~clk60MHz;

  // ROM model: registered read, constant contents selected by rom_fill.
  always_ff @(posedge clk60MHz) rom_rgb <= rom_fill;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel and hold it; return the address one cycle later and the
  // composited pixel three cycles later.
  task automatic probe(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       output logic [11:0] addr, output logic [11:0] rgb);
    @(negedge clk60MHz);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    rgb_in    = Bg;
    @(negedge clk60MHz);
    addr = rom_address;
    @(negedge clk60MHz);
    @(negedge clk60MHz);
    rgb = rgb_out;
  endtask

  // Sprite corner must be exactly at (x,y): hit there, background just outside.
  task automatic check_pos(input string tag, input logic [10:0] x, input logic [10:0] y);
    logic [11:0] a, r;
    probe(x, y, 1'b0, a, r);
    check_eq({tag, " corner addr"}, 32'(a), 32'h000);
    check_eq({tag, " corner rgb"}, 32'(r), 32'hFFF);
    if (x != 11'd0) begin
      probe(x - 11'd1, y, 1'b0, a, r);
      check_eq({tag, " left rgb"}, 32'(r), 32'(Bg));
    end
    if (y != 11'd0) begin
      probe(x, y - 11'd1, 1'b0, a, r);
      check_eq({tag, " above rgb"}, 32'(r), 32'(Bg));
    end
  endtask

  task automatic do_launch(input logic [10:0] x, input logic [10:0] y, input logic [3:0] vx);
    @(negedge clk60MHz);
    launch   = 1'b1;
    launch_x = x;
    launch_y = y;
    vel_x    = vx;
    @(negedge clk60MHz);
    launch   = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk60MHz);
    vblnk_in = 1'b1;
    hblnk_in = 1'b1;
    @(negedge clk60MHz);
    @(negedge clk60MHz);
    vblnk_in = 1'b0;
    hblnk_in = 1'b0;
  endtask

  logic [10:0] hh [10];
  logic [10:0] vh [10];
  logic [11:0] rh [10];
  logic [3:0]  sh [10];
  logic [11:0] a, r;

  initial begin
    rst_n     = 1'b0;
    hcount_in = 11'd7;
    vcount_in = 11'd9;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    hblnk_in  = 1'b1;
    vblnk_in  = 1'b0;
    rgb_in    = 12'hABC;
    launch    = 1'b0;
    launch_x  = '0;
    launch_y  = '0;
    vel_x     = '0;
    rom_fill  = 12'hFFF;

    // Reset state
    repeat (3) @(negedge clk60MHz);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset rgb_out", 32'(rgb_out), 32'd0);
    check_eq("reset addr", 32'(rom_address), 32'd0);
    check_eq("reset hcount_out", 32'(hcount_out), 32'd0);
    check_eq("reset hsync_out", 32'(hsync_out), 32'd0);
    rst_n = 1'b1;

    // Exact 3-cycle latency of every stream while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk60MHz);
      if (i >= 3) begin
        check_eq("lat hcount", 32'(hcount_out), 32'(hh[i-3]));
        check_eq("lat vcount", 32'(vcount_out), 32'(vh[i-3]));
        check_eq("lat rgb", 32'(rgb_out), 32'(rh[i-3]));
        check_eq("lat syncs", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
                 32'(sh[i-3]));
        check_eq("lat addr idle", 32'(rom_address), 32'd0);
      end
      hh[i] = 11'(i * 37 + 5);
      vh[i] = 11'(i * 11 + 2);
      rh[i] = Bg ^ 12'(i);
      sh[i] = 4'(i * 5 + 3);
      hcount_in = hh[i];
      vcount_in = vh[i];
      rgb_in    = rh[i];
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = sh[i];
    end
    check_eq("idle busy", 32'(busy), 32'd0);
    vblnk_in = 1'b0;
    hblnk_in = 1'b0;

    // Launch and sprite window
    do_launch(11'd100, 11'd200, 4'd2);
    check_eq("launch busy", 32'(busy), 32'd1);
    probe(11'd100, 11'd200, 1'b0, a, r);
    check_eq("tl addr", 32'(a), 32'h000);
    check_eq("tl rgb", 32'(r), 32'hFFF);
    probe(11'd163, 11'd263, 1'b0, a, r);
    check_eq("br addr", 32'(a), 32'hFFF);
    check_eq("br rgb", 32'(r), 32'hFFF);
    probe(11'd164, 11'd200, 1'b0, a, r);
    check_eq("right out addr", 32'(a), 32'h000);
    check_eq("right out rgb", 32'(r), 32'(Bg));
    probe(11'd100, 11'd264, 1'b0, a, r);
    check_eq("below out rgb", 32'(r), 32'(Bg));
    probe(11'd110, 11'd205, 1'b0, a, r);
    check_eq("mid addr", 32'(a), 32'h14A);
    probe(11'd110, 11'd205, 1'b1, a, r);
    check_eq("hblank addr", 32'(a), 32'h000);
    check_eq("hblank rgb", 32'(r), 32'(Bg));
    rom_fill = 12'h000;
    probe(11'd110, 11'd205, 1'b0, a, r);
    check_eq("transparent rgb", 32'(r), 32'(Bg));
    rom_fill = 12'hFFF;

    // Second launch while flying is ignored (position and velocity kept)
    do_launch(11'd300, 11'd300, 4'd5);
    check_pos("relaunch ignored", 11'd100, 11'd200);

    // Three frames of motion
    frame_pulse();
    frame_pulse();
    frame_pulse();
    check_eq("3 frames busy", 32'(busy), 32'd1);
`ifdef PARTICLE_GRAVITY_EN
    check_pos("3 frames pos", 11'd106, 11'd179);
`else
    check_pos("3 frames pos", 11'd106, 11'd176);
`endif
    // Fourth frame reaches LIFETIME = 4
    frame_pulse();
    check_eq("lifetime busy", 32'(busy), 32'd0);
    probe(11'd106, 11'd176, 1'b0, a, r);
    check_eq("retired rgb", 32'(r), 32'(Bg));
    frame_pulse();
    check_eq("idle tick busy", 32'(busy), 32'd0);

    // Right edge exit
    do_launch(11'd799, 11'd100, 4'd1);
    check_eq("right launch busy", 32'(busy), 32'd1);
    probe(11'd799, 11'd100, 1'b0, a, r);
    check_eq("right launch rgb", 32'(r), 32'hFFF);
    frame_pulse();
    check_eq("right exit busy", 32'(busy), 32'd0);

    // Left edge exit (vx = -2 from x = 1)
    do_launch(11'd1, 11'd50, 4'hE);
    check_eq("left launch busy", 32'(busy), 32'd1);
    frame_pulse();
    check_eq("left exit busy", 32'(busy), 32'd0);

    // Top edge clamp: y = 3 - 8 pins to 0 and keeps flying
    do_launch(11'd300, 11'd3, 4'd0);
    frame_pulse();
    check_eq("top clamp busy", 32'(busy), 32'd1);
    check_pos("top clamp pos", 11'd300, 11'd0);

    // Asynchronous reset mid-flight
    @(negedge clk60MHz);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst busy", 32'(busy), 32'd0);
    check_eq("async rst rgb", 32'(rgb_out), 32'd0);
    check_eq("async rst hcount", 32'(hcount_out), 32'd0);
    @(negedge clk60MHz);
    rst_n = 1'b1;
    probe(11'd300, 11'd0, 1'b0, a, r);
    check_eq("post rst rgb", 32'(r), 32'(Bg));
    check_eq("post rst addr", 32'(a), 32'h000);

    // Launch coincident with vblnk rising edge: accepted, no move that frame
    @(negedge clk60MHz);
    launch   = 1'b1;
    launch_x = 11'd200;
    launch_y = 11'd300;
    vel_x    = 4'd1;
    vblnk_in = 1'b1;
    hblnk_in = 1'b1;
    @(negedge clk60MHz);
    launch   = 1'b0;
    check_eq("coincident busy", 32'(busy), 32'd1);
    @(negedge clk60MHz);
    vblnk_in = 1'b0;
    hblnk_in = 1'b0;
    check_pos("coincident pos", 11'd200, 11'd300);
    frame_pulse();
    check_pos("coincident move", 11'd201, 11'd292);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
